// File: rtl/load_pkg.sv
// Shared definitions for the load/writeback unit: load-type encodings,
// FSM state encoding and a small funct3 legality helper.
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WB   = 2'd2
  } load_state_e;

  // True when funct3 names one of the five supported load types.
  function automatic logic funct3_legal(input logic [2:0] f3);
    logic legal_v;
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal_v = 1'b1;
      default:                             legal_v = 1'b0;
    endcase
    return legal_v;
  endfunction

endpackage

// File: rtl/load_writeback_if.sv
// Data-memory read port: the load unit requests a word, memory acknowledges
// with the read data in the same cycle as mem_ack.
interface load_writeback_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/load_align.sv
// Pure combinational load aligner: picks the addressed byte/half/word out of
// a little-endian memory word, sign- or zero-extends it, and flags loads
// that are misaligned for their size or use an unsupported funct3.
module load_align
  import load_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select: the byte and half-word addressed by the low address bits.
  always_comb begin
    byte_s = 8'h00;
    case (addr)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (addr[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extension and alignment checks per load type; unknown types yield zero.
  always_comb begin
    result     = 32'h0000_0000;
    misaligned = 1'b0;
    illegal    = ~funct3_legal(funct3);
    case (funct3)
      F3_LB:  result = {{24{byte_s[7]}}, byte_s};
      F3_LBU: result = {24'h00_0000, byte_s};
      F3_LH: begin
        result     = {{16{half_s[15]}}, half_s};
        misaligned = addr[0];
      end
      F3_LHU: begin
        result     = {16'h0000, half_s};
        misaligned = addr[0];
      end
      F3_LW: begin
        result     = rdata;
        misaligned = (addr != 2'b00);
      end
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_writeback.sv
// Load unit between execute and the register-file write port. Accepts one
// load at a time, fetches the word over a req/ack handshake, aligns and
// extends it, then writes the register file for a single cycle. The PC is
// stalled while a load is in flight.
module load_writeback
  import load_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [2:0]              load_funct3,
  input  logic [31:0]             load_addr,
  input  logic [4:0]              load_rd,
  output logic                    stall,
  output logic                    load_fault,
  load_writeback_if.master        mem,
  output logic                    write_reg,
  output logic [4:0]              target_reg,
  output logic [31:0]             write_rd_data
);

  load_state_e state_r;
  load_state_e next_state_s;

  logic [31:0] addr_r;
  logic [2:0]  funct3_r;
  logic [4:0]  rd_r;

  logic [1:0]  align_addr_s;
  logic [2:0]  align_funct3_s;
  logic [31:0] align_result_s;
  logic        misaligned_s;
  logic        illegal_s;

  logic        capture_s;
  logic        complete_s;
  logic        stall_s;
  logic        fault_s;

  // Aligner input select: live instruction while idle (for the accept-time
  // legality check), captured load otherwise (for data extraction).
  always_comb begin
    if (state_r == S_IDLE) begin
      align_addr_s   = load_addr[1:0];
      align_funct3_s = load_funct3;
    end else begin
      align_addr_s   = addr_r[1:0];
      align_funct3_s = funct3_r;
    end
  end

  load_align u_align (
    .rdata      (mem.mem_rdata),
    .addr       (align_addr_s),
    .funct3     (align_funct3_s),
    .result     (align_result_s),
    .misaligned (misaligned_s),
    .illegal    (illegal_s)
  );

  // Next-state and control decode for the IDLE -> REQ -> WB sequence.
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    complete_s   = 1'b0;
    stall_s      = 1'b0;
    fault_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (load_valid) begin
          if (misaligned_s || illegal_s) begin
            fault_s = 1'b1;
          end else begin
            stall_s      = 1'b1;
            capture_s    = 1'b1;
            next_state_s = S_REQ;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_REQ: begin
        stall_s = 1'b1;
        if (mem.mem_ack) begin
          complete_s   = 1'b1;
          next_state_s = S_WB;
        end else begin
          next_state_s = S_REQ;
        end
      end
      S_WB: begin
        next_state_s = S_IDLE;
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // State register plus load capture and writeback result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_IDLE;
      addr_r        <= 32'h0000_0000;
      funct3_r      <= 3'b000;
      rd_r          <= 5'd0;
      target_reg    <= 5'd0;
      write_rd_data <= 32'h0000_0000;
    end else begin
      state_r <= next_state_s;
      if (capture_s) begin
        addr_r   <= load_addr;
        funct3_r <= load_funct3;
        rd_r     <= load_rd;
      end
      if (complete_s) begin
        target_reg    <= rd_r;
        write_rd_data <= align_result_s;
      end
    end
  end

  // Combinational status outputs are held low while reset is applied so an
  // aborted load cannot stall or fault during reset.
  assign stall      = stall_s & ~rst;
  assign load_fault = fault_s & ~rst;

  // Handshake and write enable decoded from the registered state; x0 is
  // never written.
  assign mem.mem_req  = (state_r == S_REQ);
  assign mem.mem_addr = {addr_r[31:2], 2'b00};
  assign write_reg    = (state_r == S_WB) && (rd_r != 5'd0);

endmodule

// File: tb/tb_load_writeback.sv
// Directed self-checking bench for load_writeback. Inputs change and
// outputs are sampled around the falling clock edge; the DUT acts on rising.
module tb_load_writeback;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [2:0]  load_funct3;
  logic [31:0] load_addr;
  logic [4:0]  load_rd;
  logic        stall;
  logic        load_fault;
  logic        write_reg;
  logic [4:0]  target_reg;
  logic [31:0] write_rd_data;

  int checks;
  int errors;

  load_writeback_if mif ();

  load_writeback dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_funct3   (load_funct3),
    .load_addr     (load_addr),
    .load_rd       (load_rd),
    .stall         (stall),
    .load_fault    (load_fault),
    .mem           (mif),
    .write_reg     (write_reg),
    .target_reg    (target_reg),
    .write_rd_data (write_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one load starting at the current falling edge, with 'waits'
  // REQ cycles before the ack. Returns what was observed; ends on the
  // falling edge after WB with the instruction still presented.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input int waits,
                          output int stall_cnt, output int req_cnt,
                          output logic [31:0] maddr, output logic wr,
                          output logic [4:0] tgt, output logic [31:0] data,
                          output logic wb_stall);
    stall_cnt = 0;
    req_cnt   = 0;
    maddr     = 32'h0;
    load_valid  = 1'b1;
    load_funct3 = f3;
    load_addr   = addr;
    load_rd     = rd;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 32'h0;
    #1;
    if (stall) stall_cnt++;
    if (mif.mem_req) req_cnt++;
    @(negedge clk);
    for (int k = 0; k <= waits; k++) begin
      mif.mem_ack   = (k == waits);
      mif.mem_rdata = (k == waits) ? rdata : 32'hA5A5_A5A5;
      #1;
      if (stall) stall_cnt++;
      if (mif.mem_req) req_cnt++;
      maddr = mif.mem_addr;
      @(negedge clk);
    end
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 32'h0;
    #1;
    wr       = write_reg;
    tgt      = target_reg;
    data     = write_rd_data;
    wb_stall = stall;
    if (mif.mem_req) req_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_valid = 1'b0; load_funct3 = 3'b000; load_addr = 32'h0; load_rd = 5'd0;
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (load_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", load_fault); end
    checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mif.mem_req); end
    checks++; if (mif.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mif.mem_addr); end
    checks++; if (write_reg !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", write_reg); end
    checks++; if (target_reg !== 5'd0) begin errors++; $display("FAIL reset_tgt got %0d want 0", target_reg); end
    checks++; if (write_rd_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", write_rd_data); end
    @(negedge clk);
  endtask

  task automatic test_lw();
    int sc, rc; logic [31:0] ma, d; logic w, ws; logic [4:0] t;
    run_load(3'b010, 32'h0000_0100, 5'd5, 32'hDEAD_BEEF, 0, sc, rc, ma, w, t, d, ws);
    load_valid = 1'b0;
    #1;
    checks++; if (ma !== 32'h0000_0100) begin errors++; $display("FAIL lw_addr got %h want 00000100", ma); end
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL lw_wr got %b want 1", w); end
    checks++; if (t !== 5'd5) begin errors++; $display("FAIL lw_tgt got %0d want 5", t); end
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data got %h want deadbeef", d); end
    checks++; if (sc !== 2) begin errors++; $display("FAIL lw_stall_cycles got %0d want 2", sc); end
    checks++; if (ws !== 1'b0) begin errors++; $display("FAIL lw_wb_stall got %b want 0", ws); end
    checks++; if (rc !== 1) begin errors++; $display("FAIL lw_req_cycles got %0d want 1", rc); end
    checks++; if (mif.mem_req !== 1'b0 || write_reg !== 1'b0) begin errors++; $display("FAIL lw_no_reload got req=%b wr=%b want 0 0", mif.mem_req, write_reg); end
    @(negedge clk);
  endtask

  task automatic test_byte();
    int sc, rc; logic [31:0] ma, d; logic w, ws; logic [4:0] t;
    run_load(3'b000, 32'h0000_0103, 5'd10, 32'h8011_2233, 3, sc, rc, ma, w, t, d, ws);
    load_valid = 1'b0;
    checks++; if (d !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", d); end
    checks++; if (sc !== 5) begin errors++; $display("FAIL lb_stall_cycles got %0d want 5", sc); end
    checks++; if (rc !== 4) begin errors++; $display("FAIL lb_req_cycles got %0d want 4", rc); end
    checks++; if (ma !== 32'h0000_0100) begin errors++; $display("FAIL lb_addr got %h want 00000100", ma); end
    @(negedge clk);
    run_load(3'b100, 32'h0000_0103, 5'd11, 32'h8011_2233, 3, sc, rc, ma, w, t, d, ws);
    load_valid = 1'b0;
    checks++; if (d !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got %h want 00000080", d); end
    checks++; if (t !== 5'd11) begin errors++; $display("FAIL lbu_tgt got %0d want 11", t); end
    @(negedge clk);
    run_load(3'b000, 32'h0000_0101, 5'd12, 32'h8011_2233, 0, sc, rc, ma, w, t, d, ws);
    load_valid = 1'b0;
    checks++; if (d !== 32'h0000_0022) begin errors++; $display("FAIL lb1_data got %h want 00000022", d); end
    @(negedge clk);
  endtask

  task automatic test_half();
    int sc, rc; logic [31:0] ma, d; logic w, ws; logic [4:0] t;
    run_load(3'b001, 32'h0000_0102, 5'd3, 32'h8001_1234, 1, sc, rc, ma, w, t, d, ws);
    load_valid = 1'b0;
    checks++; if (d !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data got %h want ffff8001", d); end
    checks++; if (sc !== 3) begin errors++; $display("FAIL lh_stall_cycles got %0d want 3", sc); end
    @(negedge clk);
    run_load(3'b101, 32'h0000_0100, 5'd4, 32'h8001_1234, 0, sc, rc, ma, w, t, d, ws);
    load_valid = 1'b0;
    checks++; if (d !== 32'h0000_1234) begin errors++; $display("FAIL lhu_data got %h want 00001234", d); end
    @(negedge clk);
    run_load(3'b101, 32'h0000_0102, 5'd4, 32'h8001_1234, 0, sc, rc, ma, w, t, d, ws);
    load_valid = 1'b0;
    checks++; if (d !== 32'h0000_8001) begin errors++; $display("FAIL lhu_hi_data got %h want 00008001", d); end
    @(negedge clk);
  endtask

  task automatic test_fault();
    logic [2:0]  f3_tab [5] = '{3'b010, 3'b011, 3'b001, 3'b101, 3'b111};
    logic [31:0] ad_tab [5] = '{32'h101, 32'h100, 32'h101, 32'h103, 32'h100};
    int req_seen;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1; load_funct3 = f3_tab[i]; load_addr = ad_tab[i]; load_rd = 5'd6;
      #1;
      checks++; if (load_fault !== 1'b1) begin errors++; $display("FAIL fault_pulse[%0d] got %b want 1", i, load_fault); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fault_stall[%0d] got %b want 0", i, stall); end
      @(negedge clk);
      load_valid = 1'b0;
      req_seen = 0;
      for (int c = 0; c < 3; c++) begin
        #1;
        if (mif.mem_req !== 1'b0 || write_reg !== 1'b0 || load_fault !== 1'b0) req_seen++;
        @(negedge clk);
      end
      checks++; if (req_seen !== 0) begin errors++; $display("FAIL fault_quiet[%0d] got %0d active cycles want 0", i, req_seen); end
    end
  endtask

  task automatic test_rd0();
    int sc, rc, bad; logic [31:0] ma, d; logic w, ws; logic [4:0] t;
    run_load(3'b010, 32'h0000_0040, 5'd0, 32'h1357_9BDF, 2, sc, rc, ma, w, t, d, ws);
    load_valid = 1'b0;
    checks++; if (w !== 1'b0) begin errors++; $display("FAIL rd0_wr got %b want 0", w); end
    checks++; if (rc !== 3) begin errors++; $display("FAIL rd0_req_cycles got %0d want 3", rc); end
    @(negedge clk);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFF_0000;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (mif.mem_req !== 1'b0 || write_reg !== 1'b0 || stall !== 1'b0) bad++;
      @(negedge clk);
    end
    mif.mem_ack = 1'b0;
    #1;
    checks++; if (bad !== 0) begin errors++; $display("FAIL spurious_ack got %0d active cycles want 0", bad); end
    checks++; if (write_rd_data !== 32'h1357_9BDF) begin errors++; $display("FAIL spurious_ack_data got %h want 13579bdf", write_rd_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int sc, rc, bad; logic [31:0] ma, d; logic w, ws; logic [4:0] t;
    load_valid = 1'b1; load_funct3 = 3'b010; load_addr = 32'h0000_0200; load_rd = 5'd7;
    @(negedge clk);
    #1;
    checks++; if (mif.mem_req !== 1'b1) begin errors++; $display("FAIL mid_req_before got %b want 1", mif.mem_req); end
    rst = 1'b1;
    #1;
    checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL mid_req_drop got %b want 0", mif.mem_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_stall got %b want 0", stall); end
    checks++; if (write_reg !== 1'b0) begin errors++; $display("FAIL mid_wr got %b want 0", write_reg); end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    rst = 1'b0; load_valid = 1'b0; mif.mem_ack = 1'b0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (mif.mem_req !== 1'b0 || write_reg !== 1'b0 || load_fault !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mid_stale got %0d active cycles want 0", bad); end
    run_load(3'b010, 32'h0000_0300, 5'd9, 32'h1234_5678, 1, sc, rc, ma, w, t, d, ws);
    load_valid = 1'b0;
    checks++; if (w !== 1'b1 || t !== 5'd9) begin errors++; $display("FAIL mid_after_wr got wr=%b tgt=%0d want 1 9", w, t); end
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL mid_after_data got %h want 12345678", d); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int sc, rc; logic [31:0] ma, d; logic w, ws; logic [4:0] t;
    run_load(3'b010, 32'h0000_0400, 5'd20, 32'hCAFE_F00D, 0, sc, rc, ma, w, t, d, ws);
    checks++; if (d !== 32'hCAFE_F00D || t !== 5'd20) begin errors++; $display("FAIL b2b_first got %h/%0d want cafef00d/20", d, t); end
    run_load(3'b000, 32'h0000_0402, 5'd21, 32'h0055_0000, 0, sc, rc, ma, w, t, d, ws);
    load_valid = 1'b0;
    checks++; if (sc !== 2 || rc !== 1) begin errors++; $display("FAIL b2b_second_timing got stall=%0d req=%0d want 2 1", sc, rc); end
    checks++; if (d !== 32'h0000_0055 || t !== 5'd21 || w !== 1'b1) begin errors++; $display("FAIL b2b_second got %h/%0d/%b want 00000055/21/1", d, t, w); end
    checks++; if (ma !== 32'h0000_0400) begin errors++; $display("FAIL b2b_addr got %h want 00000400", ma); end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lw();
    test_byte();
    test_half();
    test_fault();
    test_rd0();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
